// File: rtl/pixel_write_buffer_if.sv
// Bus bundle between the memory stage, the pixel write buffer and the frame-buffer port.
// The master side drives stores and out_ready; the slave side is the buffer itself.
interface pixel_write_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int PIX_W  = 32,
   parameter int DEPTH  = 16
) ();
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic [PIX_W-1:0]  pix_data;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [PIX_W-1:0]  out_data;
   logic              out_ready;
   logic              stall_req;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output pix_we, pix_addr, pix_data, out_ready,
      input  out_valid, out_addr, out_data, stall_req, full, empty, count, overflow
   );

   modport slave (
      input  pix_we, pix_addr, pix_data, out_ready,
      output out_valid, out_addr, out_data, stall_req, full, empty, count, overflow
   );
endinterface

// File: rtl/pixel_write_buffer.sv
// FIFO of pixel stores between the memory stage and the frame-buffer port.
// stall_req rises while few entries remain free so in-flight stores always fit.
module pixel_write_buffer #(
   parameter int ADDR_W       = 32,
   parameter int PIX_W        = 32,
   parameter int DEPTH        = 16,
   parameter int STALL_MARGIN = 3
) (
   input logic                 clk,
   input logic                 reset,
   pixel_write_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + PIX_W;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(STALL_MARGIN);

   logic [ENT_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             overflow_r;

   logic             full_s;
   logic             valid_s;
   logic             push_s;
   logic             pop_s;
   logic [CNT_W-1:0] free_s;
   logic [ENT_W-1:0] head_s;

   // A store arriving while full is rejected even if the head leaves this cycle.
   assign full_s  = (count_r == DEPTH_C);
   assign valid_s = (count_r != {CNT_W{1'b0}});
   assign push_s  = bus.pix_we & ~full_s;
   assign pop_s   = valid_s & bus.out_ready;
   assign free_s  = DEPTH_C - count_r;

   // pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (bus.pix_we & full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // entry storage; contents are left untouched by reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {bus.pix_addr, bus.pix_data};
      end
   end

   // head entry presented from registered state, zero when nothing is queued
   always_comb begin
      head_s = {ENT_W{1'b0}};
      if (valid_s) begin
         head_s = mem_r[rd_ptr_r];
      end else begin
         head_s = {ENT_W{1'b0}};
      end
   end

   assign bus.out_valid = valid_s;
   assign bus.out_addr  = head_s[ENT_W-1:PIX_W];
   assign bus.out_data  = head_s[PIX_W-1:0];
   assign bus.stall_req = (free_s <= MARGIN_C);
   assign bus.full      = full_s;
   assign bus.empty     = ~valid_s;
   assign bus.count     = count_r;
   assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Randomized bench for pixel_write_buffer against a queue-based reference model.
module tb_pixel_write_buffer;
   localparam int ADDR_W = 32;
   localparam int PIX_W  = 32;
   localparam int DEPTH  = 16;
   localparam int SM     = 3;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pixel_write_buffer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH)) bus ();

   pixel_write_buffer #(
      .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH), .STALL_MARGIN(SM)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   ent_t q[$];
   bit   ovf_m;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
      bus.pix_we    = we;
      bus.pix_addr  = a;
      bus.pix_data  = d;
      bus.out_ready = rdy;
   endtask

   // One clock edge; the model applies the queue rules to the inputs seen before the edge.
   task automatic tick();
      bit full_m, push_m, pop_m;
      full_m = (q.size() == DEPTH);
      push_m = bus.pix_we && !full_m;
      pop_m  = (q.size() != 0) && bus.out_ready;
      @(posedge clk);
      if (bus.pix_we && full_m) ovf_m = 1'b1;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back('{a: bus.pix_addr, d: bus.pix_data});
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      #7;
      q.delete();
      ovf_m = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      #12;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.stall_req !== 1'b0 || bus.overflow !== 1'b0 || bus.out_addr !== 32'h0 || bus.out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b stall=%b ovf=%b addr=%h data=%h, required 0 1 0 0 0 0 0 0",
                  bus.count, bus.empty, bus.full, bus.out_valid, bus.stall_req, bus.overflow, bus.out_addr, bus.out_data);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b count=%0d, required 0 0", bus.out_valid, bus.count);
      end
      q.delete();
      ovf_m = 1'b0;
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 32'h0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: count=%0d empty=%b valid=%b addr=%h ovf=%b, required 0 1 0 0 0",
                  bus.count, bus.empty, bus.out_valid, bus.out_addr, bus.overflow);
      end
      drive(1'b1, 32'h100, 32'hFF0000, 1'b0);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_bypass: valid=%b before edge, required 0", bus.out_valid);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'h100 || bus.out_data !== 32'hFF0000) begin
         n_fail++;
         $display("FAIL first_push: valid=%b addr=%h data=%h, required 1 100 ff0000", bus.out_valid, bus.out_addr, bus.out_data);
      end
   endtask

   task automatic test_ordered_drain();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i), 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      n_tests++;
      if (bus.count !== 5'd5 || bus.out_addr !== 32'h10 || bus.out_data !== 32'hA0) begin
         n_fail++;
         $display("FAIL drain_fill: count=%0d addr=%h data=%h, required 5 10 a0", bus.count, bus.out_addr, bus.out_data);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'h10 + 32'(i) || bus.out_data !== 32'hA0 + 32'(i)) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: valid=%b addr=%h data=%h, required 1 %h %h",
                     i, bus.out_valid, bus.out_addr, bus.out_data, 32'h10 + 32'(i), 32'hA0 + 32'(i));
         end
         tick();
      end
      n_tests++;
      if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: empty=%b valid=%b, required 1 0", bus.empty, bus.out_valid);
      end
   endtask

   task automatic test_full_overflow();
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
         if (i == 11) begin
            n_tests++;
            if (bus.stall_req !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_at_12: stall=%b, required 0", bus.stall_req);
            end
         end
      end
      n_tests++;
      if (bus.stall_req !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd13) begin
         n_fail++;
         $display("FAIL stall_at_13: stall=%b full=%b count=%0d, required 1 0 13", bus.stall_req, bus.full, bus.count);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
      end
      n_tests++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_16: full=%b count=%0d ovf=%b, required 1 16 0", bus.full, bus.count, bus.overflow);
      end
      drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
      tick();
      n_tests++;
      if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_17: count=%0d ovf=%b, required 16 1", bus.count, bus.overflow);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      while (q.size() != 0) begin
         n_tests++;
         if (bus.out_addr !== q[0].a || bus.out_data !== q[0].d) begin
            n_fail++;
            $display("FAIL full_drain: addr=%h data=%h, required %h %h", bus.out_addr, bus.out_data, q[0].a, q[0].d);
         end
         tick();
      end
      n_tests++;
      if (bus.overflow !== 1'b1 || bus.empty !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky: ovf=%b empty=%b, required 1 1", bus.overflow, bus.empty);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b1);
         tick();
         n_tests++;
         if (bus.count !== 5'd4 || bus.out_addr !== q[0].a || bus.out_data !== q[0].d) begin
            n_fail++;
            $display("FAIL simul_4[%0d]: count=%0d addr=%h data=%h, required 4 %h %h",
                     i, bus.count, bus.out_addr, bus.out_data, q[0].a, q[0].d);
         end
      end
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
      end
      drive(1'b1, 32'hCAFE, 32'hF00D, 1'b1);
      tick();
      n_tests++;
      if (bus.count !== 5'd15 || bus.overflow !== 1'b1 || bus.full !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_full: count=%0d ovf=%b full=%b, required 15 1 0", bus.count, bus.overflow, bus.full);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      while (q.size() != 0) begin
         n_tests++;
         if (bus.out_addr !== q[0].a || bus.out_data !== q[0].d) begin
            n_fail++;
            $display("FAIL simul_drain: addr=%h data=%h, required %h %h", bus.out_addr, bus.out_data, q[0].a, q[0].d);
         end
         tick();
      end
   endtask

   task automatic test_wraparound();
      logic [31:0] ea, ed;
      bit ev;
      apply_reset();
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 99) < 55), $urandom, $urandom, ($urandom_range(0, 99) < 50));
         tick();
         ev = (q.size() != 0);
         ea = ev ? q[0].a : 32'h0;
         ed = ev ? q[0].d : 32'h0;
         n_tests++;
         if (bus.out_valid !== ev || bus.out_addr !== ea || bus.out_data !== ed ||
             bus.count !== 5'(q.size()) || bus.full !== (q.size() == DEPTH) ||
             bus.stall_req !== ((DEPTH - q.size()) <= SM) || bus.overflow !== ovf_m) begin
            n_fail++;
            $display("FAIL wrap[%0d]: valid=%b addr=%h data=%h count=%0d full=%b stall=%b ovf=%b, required %b %h %h %0d %b %b %b",
                     i, bus.out_valid, bus.out_addr, bus.out_data, bus.count, bus.full, bus.stall_req, bus.overflow,
                     ev, ea, ed, q.size(), (q.size() == DEPTH), ((DEPTH - q.size()) <= SM), ovf_m);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ha, hd;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0);
         tick();
      end
      ha = q[0].a;
      hd = q[0].d;
      for (int i = 0; i < 8; i++) begin
         drive(i[0], $urandom, $urandom, 1'b0);
         tick();
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_addr !== ha || bus.out_data !== hd || bus.count !== 5'(q.size())) begin
            n_fail++;
            $display("FAIL backpressure[%0d]: valid=%b addr=%h data=%h count=%0d, required 1 %h %h %0d",
                     i, bus.out_valid, bus.out_addr, bus.out_data, bus.count, ha, hd, q.size());
         end
      end
      n_tests++;
      if (bus.count !== 5'd7) begin
         n_fail++;
         $display("FAIL backpressure_count: count=%0d, required 7", bus.count);
      end
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      test_reset();
      test_ordered_drain();
      test_full_overflow();
      test_simultaneous();
      test_wraparound();
      test_backpressure();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
